// File: rtl/adc_ltc2308_capture_pkg.sv
// Shared types and helpers for the LTC2308 capture front end.
package adc_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONVST,
        WAIT_CONV,
        SHIFT,
        DONE
    } cap_state_t;

    localparam int unsigned LTC_CFG_BITS = 6;
    localparam int unsigned FRAME_BITS   = 12;

    // Config word {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, no sleep.
    function automatic logic [LTC_CFG_BITS-1:0] ltc_cfg(input logic [2:0] ch);
        return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    endfunction

endpackage

// File: rtl/ltc2308_shift.sv
// SCK generator with SDO shift-in and SDI config shift-out for one 12-bit LTC2308 frame.
module ltc2308_shift
    import adc_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           channel,
    input  logic                 adc_sdo,
    output logic                 adc_sck,
    output logic                 adc_sdi,
    output logic [DATA_BITS-1:0] data,
    output logic                 done_c
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HALVES = 2 * FRAME_BITS;
    localparam int unsigned HALF_W = $clog2(HALVES);

    logic                    active_q, active_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [HALF_W-1:0]       half_q, half_d;
    logic                    sck_q, sck_d;
    logic                    sdi_q, sdi_d;
    logic [LTC_CFG_BITS-1:0] cfg_q, cfg_d;
    logic [DATA_BITS-1:0]    sreg_q, sreg_d;
    logic [LTC_CFG_BITS-1:0] cfg_new;

    assign adc_sck = sck_q;
    assign adc_sdi = sdi_q;
    assign data    = sreg_q;

    // Half-period divider; SDO sampled on SCK rise, SDI advanced on SCK fall.
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        half_d   = half_q;
        sck_d    = sck_q;
        sdi_d    = sdi_q;
        cfg_d    = cfg_q;
        sreg_d   = sreg_q;
        done_c   = 1'b0;
        cfg_new  = ltc_cfg(channel);
        if (start) begin
            active_d = 1'b1;
            div_d    = '0;
            half_d   = '0;
            sck_d    = 1'b0;
            cfg_d    = cfg_new;
            sdi_d    = cfg_new[LTC_CFG_BITS-1];
            sreg_d   = '0;
        end else if (active_q) begin
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
                div_d  = '0;
                sck_d  = ~sck_q;
                half_d = half_q + HALF_W'(1);
                if (!sck_q) begin
                    sreg_d = {sreg_q[DATA_BITS-2:0], adc_sdo};
                end else begin
                    // Shifting in zeros leaves sdi low once the six config bits are out.
                    cfg_d = {cfg_q[LTC_CFG_BITS-2:0], 1'b0};
                    sdi_d = cfg_q[LTC_CFG_BITS-2];
                end
                if (half_q == HALF_W'(HALVES - 1)) begin
                    active_d = 1'b0;
                    done_c   = 1'b1;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            div_q    <= '0;
            half_q   <= '0;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            cfg_q    <= '0;
            sreg_q   <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            half_q   <= half_d;
            sck_q    <= sck_d;
            sdi_q    <= sdi_d;
            cfg_q    <= cfg_d;
            sreg_q   <= sreg_d;
        end
    end

endmodule

// File: rtl/adc_ltc2308_capture.sv
// Periodic LTC2308 sampler: period counter, conversion FSM and sample output registers.
module adc_ltc2308_capture
    import adc_capture_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned CONVST_CYCLES = 2,
    parameter int unsigned CONV_CYCLES   = 80,
    parameter int unsigned DATA_BITS     = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           channel,
    input  logic                 adc_sdo,
    output logic                 adc_convst,
    output logic                 adc_sck,
    output logic                 adc_sdi,
    output logic [DATA_BITS-1:0] sample_out,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned LATENCY = CONVST_CYCLES + CONV_CYCLES + 2 * FRAME_BITS * CLK_DIV + 1;
    localparam int unsigned PER_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned CNT_MAX = (CONV_CYCLES > CONVST_CYCLES) ? CONV_CYCLES : CONVST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // A period shorter than one frame would turn every tick into an overrun.
    if (SAMPLE_PERIOD <= LATENCY) begin : g_bad_period
        $fatal(1, "adc_ltc2308_capture: SAMPLE_PERIOD %0d must exceed latency %0d",
               SAMPLE_PERIOD, LATENCY);
    end
    if (DATA_BITS != FRAME_BITS) begin : g_bad_width
        $fatal(1, "adc_ltc2308_capture: DATA_BITS must be %0d", FRAME_BITS);
    end

    cap_state_t           state_q, state_d;
    logic [PER_W-1:0]     per_q, per_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 convst_q, convst_d;
    logic [DATA_BITS-1:0] sample_q, sample_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 tick_c;
    logic                 start_c;
    logic                 shift_done_c;
    logic [DATA_BITS-1:0] shift_data;

    assign adc_convst   = convst_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

    // Period counter; parked at zero while disabled so re-enable ticks at once.
    always_comb begin
        tick_c = enable && (per_q == '0);
        per_d  = '0;
        if (enable && (per_q != PER_W'(SAMPLE_PERIOD - 1))) begin
            per_d = per_q + PER_W'(1);
        end
    end

    // Conversion sequencing; ticks that land mid-frame are dropped and flagged.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        start_c   = 1'b0;
        overrun_d = overrun_q | (tick_c && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (tick_c) begin
                    state_d = CONVST;
                    cnt_d   = '0;
                end
            end
            CONVST: begin
                if (cnt_q == CNT_W'(CONVST_CYCLES - 1)) begin
                    state_d = WAIT_CONV;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_CONV: begin
                if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    start_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (shift_done_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                sample_d = shift_data;
                valid_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        convst_d = (state_d == CONVST);
        busy_d   = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            per_q     <= '0;
            cnt_q     <= '0;
            convst_q  <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            convst_q  <= convst_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    ltc2308_shift #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .start   (start_c),
        .channel (channel),
        .adc_sdo (adc_sdo),
        .adc_sck (adc_sck),
        .adc_sdi (adc_sdi),
        .data    (shift_data),
        .done_c  (shift_done_c)
    );

endmodule

// File: tb/tb_adc_ltc2308_capture.sv
// Bench for adc_ltc2308_capture: LTC2308 behavioural model plus sample scoreboard.
module tb_adc_ltc2308_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  channel;
    logic        adc_sdo;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;
    int base  = 0;

    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    adc_ltc2308_capture dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .channel      (channel),
        .adc_sdo      (adc_sdo),
        .adc_convst   (adc_convst),
        .adc_sck      (adc_sck),
        .adc_sdi      (adc_sdi),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Advance to the falling edge that follows tick-relative posedge t.
    task automatic goto(input int t);
        while ((ecnt - base) < t) @(negedge clk);
    endtask

    // ADC model: result code is A5C xor the channel selected by the previous frame's config word.
    logic [11:0] m_sh   = 12'h000;
    logic [11:0] m_hist = 12'h000;
    logic [2:0]  m_pend = 3'd0;
    int          m_n    = 0;
    logic        m_convst = 1'b0;
    logic        m_sck    = 1'b0;

    assign adc_sdo = m_sh[11];

    always @(negedge clk) begin
        if (adc_convst && !m_convst) begin
            m_sh   <= 12'hA5C ^ {9'd0, m_pend};
            m_hist <= 12'h000;
            m_n    <= 0;
        end else begin
            if (!adc_sck && m_sck) m_sh <= {m_sh[10:0], 1'b0};
            if (adc_sck && !m_sck) begin
                m_hist <= {m_hist[10:0], adc_sdi};
                m_n    <= m_n + 1;
                if (m_n == 5) m_pend <= {m_hist[2], m_hist[1], m_hist[3]};
            end
        end
        m_convst <= adc_convst;
        m_sck    <= adc_sck;
    end

    // Monitor: convst rise log, strobe width and scoreboard pop on every sample_valid.
    int   n_convst    = 0;
    int   n_valid     = 0;
    int   last_convst = -1;
    int   last_valid  = -1;
    logic mon_convst  = 1'b0;
    logic mon_valid   = 1'b0;

    always @(negedge clk) begin
        if (adc_convst && !mon_convst) begin
            n_convst    <= n_convst + 1;
            last_convst <= ecnt;
        end
        if (sample_valid) begin
            n_valid    <= n_valid + 1;
            last_valid <= ecnt;
            chk("valid_width", int'(mon_valid), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", int'(sample_out), -1);
            end else begin
                chk("sample_out", int'(sample_out), int'(exp_q.pop_front()));
            end
        end
        mon_convst <= adc_convst;
        mon_valid  <= sample_valid;
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_convst"},  int'(adc_convst),   0);
        chk({tag, "_sck"},     int'(adc_sck),      0);
        chk({tag, "_sdi"},     int'(adc_sdi),      0);
        chk({tag, "_sample"},  int'(sample_out),   0);
        chk({tag, "_valid"},   int'(sample_valid), 0);
        chk({tag, "_busy"},    int'(busy),         0);
        chk({tag, "_overrun"}, int'(overrun),      0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        channel = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_values("rst");

        // Frame 1: power-up channel 0; config for channel 5 goes out on SDI.
        channel = 3'd5;
        exp_q.push_back(12'hA5C);
        enable = 1'b1;
        base   = ecnt + 1;
        goto(2);
        chk("f1_convst_time", last_convst - base, 0);
        goto(100);
        chk("f1_busy_shift", int'(busy), 1);
        goto(132);
        chk("f1_valid_time", last_valid - base, 131);
        chk("f1_sdi_bits", int'(m_hist), int'(12'b111010_000000));
        chk("f1_busy_done", int'(busy), 0);

        // Frame 2: reports channel 5; only the channel value at SHIFT entry counts.
        goto(500);
        channel = 3'd3;
        exp_q.push_back(12'hA59);
        goto(1002);
        chk("f2_convst_time", last_convst - base, 1000);
        goto(1010);
        channel = 3'd7;
        goto(1050);
        enable = 1'b0;
        goto(1070);
        channel = 3'd3;
        goto(1090);
        channel = 3'd0;
        goto(1132);
        chk("f2_valid_time", last_valid - base, 1131);
        chk("f2_busy_after", int'(busy), 0);
        goto(2100);
        chk("dis_convst_count", n_convst, 2);
        chk("dis_busy", int'(busy), 0);
        chk("dis_overrun", int'(overrun), 0);

        // Frame 3: reports channel 3; an enable blip mid-SHIFT forces a dropped tick.
        channel = 3'd6;
        exp_q.push_back(12'hA5F);
        enable = 1'b1;
        base   = ecnt + 1;
        goto(2);
        chk("f3_convst_time", last_convst - base, 0);
        goto(99);
        enable = 1'b0;
        goto(100);
        enable = 1'b1;
        goto(103);
        chk("ovr_set", int'(overrun), 1);
        goto(132);
        chk("ovr_convst_count", n_convst, 3);
        chk("f3_valid_time", last_valid - base, 131);
        chk("f3_valid_count", n_valid, 3);

        // Frame 4: counter restarted on the dropped tick; reports channel 6.
        channel = 3'd1;
        exp_q.push_back(12'hA5A);
        base = base + 101 + 1000;
        goto(2);
        chk("f4_convst_time", last_convst - base, 0);
        chk("f4_convst_count", n_convst, 4);
        goto(132);
        chk("f4_valid_time", last_valid - base, 131);
        chk("ovr_sticky", int'(overrun), 1);

        // Frame 5: reset during SHIFT abandons the frame.
        base = base + 1000;
        goto(2);
        chk("f5_convst_time", last_convst - base, 0);
        goto(100);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_values("midrst");
        goto(140);
        chk("midrst_no_valid", n_valid, 4);
        reset = 1'b0;

        // Frame 6: immediate tick after reset; ADC still holds channel 1 config.
        exp_q.push_back(12'hA5D);
        base = ecnt + 1;
        goto(2);
        chk("f6_convst_time", last_convst - base, 0);
        goto(132);
        chk("f6_valid_time", last_valid - base, 131);
        chk("total_valid", n_valid, 5);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
